// File: rtl/multichannel_frequency_counter.sv
// Measures CHANNELS external clocks against one gate window derived from clk.
// Inputs are synchronized into clk; results are latched together per window.
module multichannel_frequency_counter #(
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned COUNTER_WIDTH = 28,
    parameter int unsigned GATE_WIDTH    = 28,
    parameter int unsigned SEL_WIDTH     = 4
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic                     enable,
    input  logic [CHANNELS-1:0]      iclk,
    input  logic [GATE_WIDTH-1:0]    gate_period,
    input  logic [SEL_WIDTH-1:0]     sel,
    output logic [COUNTER_WIDTH-1:0] code,
    output logic                     overflow,
    output logic                     valid,
    output logic                     interrupt,
    input  logic                     interrupt_clear
);
    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX    = '1;
    localparam logic [GATE_WIDTH-1:0]    MIN_PERIOD = GATE_WIDTH'(2);

    logic [CHANNELS-1:0]                     sync1;
    logic [CHANNELS-1:0]                     sync2;
    logic [CHANNELS-1:0]                     prev;
    logic [CHANNELS-1:0]                     edge_c;
    logic [CHANNELS-1:0][COUNTER_WIDTH-1:0]  cnt;
    logic [CHANNELS-1:0][COUNTER_WIDTH-1:0]  cnt_next_c;
    logic [CHANNELS-1:0]                     ovf;
    logic [CHANNELS-1:0]                     ovf_next_c;
    logic [CHANNELS-1:0][COUNTER_WIDTH-1:0]  result_reg;
    logic [CHANNELS-1:0]                     ovf_reg;
    logic [GATE_WIDTH-1:0]                   gate_cnt;
    logic [GATE_WIDTH-1:0]                   period_q;
    logic                                    boundary_c;
    logic                                    boundary_q;
    logic [COUNTER_WIDTH-1:0]                code_c;
    logic                                    overflow_c;

    // Two-flop synchronizer plus edge-detect flop per channel
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= iclk;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign edge_c = sync2 & ~prev;

    // Saturating increment; overflow marks that all-ones was reached this window
    always_comb begin
        cnt_next_c = cnt;
        ovf_next_c = ovf;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (edge_c[i] && (cnt[i] != CNT_MAX)) begin
                cnt_next_c[i] = cnt[i] + COUNTER_WIDTH'(1);
            end
            ovf_next_c[i] = ovf[i] | (cnt_next_c[i] == CNT_MAX);
        end
    end

    // Window length is captured in the count-0 cycle, so a window never ends there
    assign boundary_c = enable && (gate_cnt != '0) && (gate_cnt == period_q - GATE_WIDTH'(1));

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            gate_cnt <= '0;
            period_q <= '0;
        end else if (!enable) begin
            gate_cnt <= '0;
        end else begin
            if (gate_cnt == '0) begin
                period_q <= (gate_period < MIN_PERIOD) ? MIN_PERIOD : gate_period;
            end
            gate_cnt <= boundary_c ? '0 : gate_cnt + GATE_WIDTH'(1);
        end
    end

    // Edge counters and window-end latch; a boundary-cycle edge closes with its window
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt        <= '0;
            ovf        <= '0;
            result_reg <= '0;
            ovf_reg    <= '0;
        end else begin
            if (!enable || boundary_c) begin
                cnt <= '0;
                ovf <= '0;
            end else begin
                cnt <= cnt_next_c;
                ovf <= ovf_next_c;
            end
            if (boundary_c) begin
                result_reg <= cnt_next_c;
                ovf_reg    <= ovf_next_c;
            end
        end
    end

    // Status flags trail the boundary by one cycle, aligned with the readout register
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            boundary_q <= 1'b0;
            valid      <= 1'b0;
            interrupt  <= 1'b0;
        end else begin
            boundary_q <= boundary_c;
            if (!enable) begin
                valid <= 1'b0;
            end else if (boundary_q) begin
                valid <= 1'b1;
            end
            if (boundary_q) begin
                interrupt <= 1'b1;
            end else if (interrupt_clear) begin
                interrupt <= 1'b0;
            end
        end
    end

    // Readout mux; out-of-range select reads zero
    always_comb begin
        code_c     = '0;
        overflow_c = 1'b0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (sel == SEL_WIDTH'(i)) begin
                code_c     = result_reg[i];
                overflow_c = ovf_reg[i];
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            code     <= '0;
            overflow <= 1'b0;
        end else begin
            code     <= code_c;
            overflow <= overflow_c;
        end
    end

endmodule
